// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core sequencer: state encoding, opcode constants
// and default widths.
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StWb     = 3'd3,
        StHalted = 3'd4
    } seqState_t;

    localparam logic [3:0]  OP_HLT      = 4'h3;
    localparam logic [3:0]  OP_WR       = 4'hA;

    localparam int unsigned DEF_PC_W    = 16;
    localparam int unsigned DEF_INSTR_W = 16;
    localparam int unsigned EXEC_CNT_W  = 4;

endpackage

// File: rtl/core_sequencer_exec_timer.sv
// Loadable down-counter with a zero flag; saturates at zero.
module core_sequencer_exec_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_loadVal,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] cntQ, cntD;

    always_comb begin
        cntD = cntQ;
        if (i_load) begin
            cntD = i_loadVal;
        end else if (i_dec && (cntQ != '0)) begin
            cntD = cntQ - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign o_count = cntQ;
    assign o_zero  = (cntQ == '0);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: fetch over req/ack, decode, execute, write back,
// with halt/resume. Owns the PC and the instruction register.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int unsigned     PC_W        = DEF_PC_W,
    parameter int unsigned     INSTR_W     = DEF_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned     EXEC_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    output logic               o_memReq,
    output logic [PC_W-1:0]    o_memAddr,
    input  logic               i_memAck,
    input  logic [INSTR_W-1:0] i_memData,
    output logic [INSTR_W-1:0] o_instr,
    output logic [3:0]         o_opcode,
    input  logic               i_wrReg,
    input  logic               i_isHLT,
    output logic               o_regWrEn,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_halted,
    input  logic               i_resume
);

    localparam logic [EXEC_CNT_W-1:0] EXEC_LOAD = EXEC_CNT_W'(EXEC_CYCLES - 1);

    seqState_t            stateQ, stateD;
    logic [PC_W-1:0]      pcQ, pcD;
    logic [INSTR_W-1:0]   instrQ, instrD;
    logic                 wrRegQ, wrRegD;
    logic                 memReqQ, memReqD;
    logic                 tmrLoad, tmrDec, tmrZero;
    logic [EXEC_CNT_W-1:0] tmrCount;

    core_sequencer_exec_timer #(
        .CNT_W (EXEC_CNT_W)
    ) u_execTimer (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_load    (tmrLoad),
        .i_loadVal (EXEC_LOAD),
        .i_dec     (tmrDec),
        .o_count   (tmrCount),
        .o_zero    (tmrZero)
    );

    always_comb begin
        stateD  = stateQ;
        pcD     = pcQ;
        instrD  = instrQ;
        wrRegD  = wrRegQ;
        tmrLoad = 1'b0;
        tmrDec  = 1'b0;
        unique case (stateQ)
            StFetch: begin
                // Gating on memReqQ drops acks that straddle reset release.
                if (memReqQ && i_memAck) begin
                    instrD = i_memData;
                    pcD    = pcQ + PC_W'(1);
                    stateD = StDecode;
                end
            end
            StDecode: begin
                if (i_isHLT) begin
                    stateD = StHalted;
                end else begin
                    wrRegD  = i_wrReg;
                    tmrLoad = 1'b1;
                    stateD  = StExec;
                end
            end
            StExec: begin
                if (tmrZero) begin
                    stateD = wrRegQ ? StWb : StFetch;
                end else begin
                    tmrDec = 1'b1;
                end
            end
            StWb: stateD = StFetch;
            StHalted: begin
                if (i_resume) begin
                    stateD = StFetch;
                end
            end
            default: stateD = StFetch;
        endcase
        memReqD = (stateD == StFetch);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stateQ  <= StFetch;
            pcQ     <= RESET_PC;
            instrQ  <= '0;
            wrRegQ  <= 1'b0;
            memReqQ <= 1'b0;
        end else begin
            stateQ  <= stateD;
            pcQ     <= pcD;
            instrQ  <= instrD;
            wrRegQ  <= wrRegD;
            memReqQ <= memReqD;
        end
    end

    assign o_memReq  = memReqQ;
    assign o_memAddr = pcQ;
    assign o_pc      = pcQ;
    assign o_instr   = instrQ;
    assign o_opcode  = instrQ[INSTR_W-1 -: 4];
    assign o_regWrEn = (stateQ == StWb);
    assign o_halted  = (stateQ == StHalted);

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer; a second instance starts at
// PC 0xFFFF to exercise the wrap.
module tb_core_sequencer;
    import core_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    int          nChecks = 0;
    int          nErrors = 0;

    // Main instance, RESET_PC = 0x0010
    logic        memReq, memAck, wrReg, isHLT, regWrEn, halted, resume;
    logic [15:0] memAddr, memData, instr, pc;
    logic [3:0]  opcode;

    // Wrap instance, RESET_PC = 0xFFFF
    logic        memReqW, memAckW, wrRegW, isHLTW, regWrEnW, haltedW;
    logic [15:0] memAddrW, memDataW, instrW, pcW;
    logic [3:0]  opcodeW;

    always #5 clk = ~clk;

    // Stand-in for the opcode decoder
    assign wrReg  = (opcode == OP_WR);
    assign isHLT  = (opcode == OP_HLT);
    assign wrRegW = (opcodeW == OP_WR);
    assign isHLTW = (opcodeW == OP_HLT);

    core_sequencer #(
        .PC_W (16), .INSTR_W (16), .RESET_PC (16'h0010), .EXEC_CYCLES (2)
    ) dut (
        .i_clk (clk), .i_rstn (rstn),
        .o_memReq (memReq), .o_memAddr (memAddr), .i_memAck (memAck), .i_memData (memData),
        .o_instr (instr), .o_opcode (opcode), .i_wrReg (wrReg), .i_isHLT (isHLT),
        .o_regWrEn (regWrEn), .o_pc (pc), .o_halted (halted), .i_resume (resume)
    );

    core_sequencer #(
        .PC_W (16), .INSTR_W (16), .RESET_PC (16'hFFFF), .EXEC_CYCLES (2)
    ) dutW (
        .i_clk (clk), .i_rstn (rstn),
        .o_memReq (memReqW), .o_memAddr (memAddrW), .i_memAck (memAckW),
        .i_memData (memDataW), .o_instr (instrW), .o_opcode (opcodeW), .i_wrReg (wrRegW),
        .i_isHLT (isHLTW), .o_regWrEn (regWrEnW), .o_pc (pcW), .o_halted (haltedW),
        .i_resume (1'b0)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b1; memAck = 1'b0; memData = '0; resume = 1'b0;
        memAckW = 1'b0; memDataW = '0;
        #1 rstn = 1'b0;
        #1;
        checkVal("rst_memReq", 32'(memReq), 0);
        checkVal("rst_pc", 32'(pc), 'h10);
        checkVal("rst_instr", 32'(instr), 0);
        checkVal("rst_regWrEn", 32'(regWrEn), 0);
        checkVal("rst_halted", 32'(halted), 0);
        repeat (2) tick();
        rstn = 1'b1;

        // Zero-wait write instruction
        tick();
        checkVal("t1_req", 32'(memReq), 1);
        checkVal("t1_addr", 32'(memAddr), 'h10);
        memAck = 1'b1; memData = 16'hA123;
        tick();
        memAck = 1'b0;
        checkVal("t1_instr", 32'(instr), 'hA123);
        checkVal("t1_pc", 32'(pc), 'h11);
        checkVal("t1_opcode", 32'(opcode), 'hA);
        checkVal("t1_reqDrop", 32'(memReq), 0);
        checkVal("t1_wr1", 32'(regWrEn), 0);
        for (int k = 2; k <= 4; k++) begin
            tick();
            checkVal("t1_wrPulse", 32'(regWrEn), (k == 4) ? 1 : 0);
        end
        tick();
        checkVal("t1_wrEnd", 32'(regWrEn), 0);
        checkVal("t1_nextReq", 32'(memReq), 1);
        checkVal("t1_nextAddr", 32'(memAddr), 'h11);

        // Non-write opcode, ack after 3 wait cycles
        for (int k = 0; k < 3; k++) begin
            tick();
            checkVal("t2_reqHeld", 32'(memReq), 1);
            checkVal("t2_addr", 32'(memAddr), 'h11);
        end
        memAck = 1'b1; memData = 16'h5000;
        tick();
        memData = 16'hBEEF;  // spurious ack during DECODE
        checkVal("t2_instr", 32'(instr), 'h5000);
        checkVal("t2_pc", 32'(pc), 'h12);
        tick();
        memAck = 1'b0; resume = 1'b1;  // spurious resume during EXEC
        checkVal("t4_instrDec", 32'(instr), 'h5000);
        checkVal("t4_pcDec", 32'(pc), 'h12);
        tick();
        resume = 1'b0;
        checkVal("t2_execReq", 32'(memReq), 0);
        checkVal("t4_halted", 32'(halted), 0);
        checkVal("t2_noWr", 32'(regWrEn), 0);
        tick();
        checkVal("t2_backFetch", 32'(memReq), 1);
        checkVal("t2_backAddr", 32'(memAddr), 'h12);
        checkVal("t4_instr", 32'(instr), 'h5000);

        // Halt, spurious acks, resume
        memAck = 1'b1; memData = 16'h3000;
        tick();
        memAck = 1'b0;
        checkVal("t3_notYet", 32'(halted), 0);
        tick();
        checkVal("t3_halted", 32'(halted), 1);
        checkVal("t3_req", 32'(memReq), 0);
        checkVal("t3_pc", 32'(pc), 'h13);
        memAck = 1'b1; memData = 16'h7777;
        for (int k = 0; k < 2; k++) begin
            tick();
            checkVal("t3_spurInstr", 32'(instr), 'h3000);
            checkVal("t3_spurPc", 32'(pc), 'h13);
            checkVal("t3_stillHalt", 32'(halted), 1);
        end
        memAck = 1'b0; resume = 1'b1;
        tick();
        resume = 1'b0;
        checkVal("t3_resumed", 32'(halted), 0);
        checkVal("t3_req", 32'(memReq), 1);
        checkVal("t3_addr", 32'(memAddr), 'h13);

        // Reset mid-FETCH, with an ack straddling the release
        #2 rstn = 1'b0; memAck = 1'b1; memData = 16'h9999;
        #1;
        checkVal("t6_reqAsync", 32'(memReq), 0);
        checkVal("t6_pcAsync", 32'(pc), 'h10);
        tick();
        rstn = 1'b1;
        tick();
        memAck = 1'b0;
        checkVal("t6_lateAckPc", 32'(pc), 'h10);
        checkVal("t6_lateAckInstr", 32'(instr), 0);
        checkVal("t6_req", 32'(memReq), 1);
        checkVal("t6_addr", 32'(memAddr), 'h10);

        // Reset mid-WB
        memAck = 1'b1; memData = 16'hA000;
        tick();
        memAck = 1'b0;
        repeat (3) tick();
        checkVal("t6_inWb", 32'(regWrEn), 1);
        #2 rstn = 1'b0;
        #1;
        checkVal("t6_wrAsync", 32'(regWrEn), 0);
        checkVal("t6_pcWb", 32'(pc), 'h10);
        tick();
        rstn = 1'b1;
        tick();
        checkVal("t6_cleanReq", 32'(memReq), 1);
        checkVal("t6_cleanAddr", 32'(memAddr), 'h10);

        // PC wrap on the second instance
        checkVal("t5_addr", 32'(memAddrW), 'hFFFF);
        memAckW = 1'b1; memDataW = 16'hA000;
        tick();
        memAckW = 1'b0;
        checkVal("t5_pcWrap", 32'(pcW), 0);
        checkVal("t5_instr", 32'(instrW), 'hA000);
        repeat (3) tick();
        checkVal("t5_wr", 32'(regWrEnW), 1);
        tick();
        checkVal("t5_nextAddr", 32'(memAddrW), 0);
        checkVal("t5_nextReq", 32'(memReqW), 1);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
